pwm_multichannel_shadowed: RTL

//   Parametrised N-channel PWM generator with a shared prescaler and a shared duty counter.

---
 rtl/pwm_multichannel_shadowed.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_multichannel_shadowed.sv
// N-channel PWM generator: shared prescaler and duty counter, per-channel shadowed duty registers.
// Duty writes wait in a pending slot and commit to the active threshold only at a period boundary.
module pwm_multichannel_shadowed #(
  parameter int CHANNELS   = 3,
  parameter int RES        = 7,
  parameter int PRESC_W    = 32,
  parameter int DVSR_FAST  = 10416,
  parameter int DVSR_SERVO = 200000,
  parameter int SERVO_MIN  = 6,
  parameter int SERVO_SPAN = 7,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [CW-1:0]       wr_chan_i,
  input  logic [RES-1:0]      wr_duty_i,
  output logic                wr_err_o,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);

  localparam int SPAN_W = (SERVO_SPAN > 0) ? $clog2(SERVO_SPAN + 1) : 1;
  localparam int PW     = RES + SPAN_W;

  // Servo mapping keeps the full product width so the shift sees every bit.
  function automatic logic [RES-1:0] thr(input logic [RES-1:0] x, input logic servo);
    logic [PW-1:0] prod;
    logic [PW-1:0] mapped;
    prod   = PW'(x) * PW'(SERVO_SPAN);
    mapped = PW'(SERVO_MIN) + (prod >> RES);
    thr    = servo ? mapped[RES-1:0] : x;
  endfunction

  logic [PRESC_W-1:0]  q_q, q_d, dvsr;
  logic [RES-1:0]      d_q, d_d;
  logic [RES-1:0]      active_q  [CHANNELS];
  logic [RES-1:0]      active_d  [CHANNELS];
  logic [RES-1:0]      pending_q [CHANNELS];
  logic [RES-1:0]      pending_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                mode_q, mode_d;
  logic                period_q, period_d;
  logic                err_q, err_d;
  logic                tick, boundary, chan_ok, accept;

  // Prescaler and duty counter; both held at zero while disabled so enable starts a fresh period.
  always_comb begin
    dvsr     = mode_q ? PRESC_W'(DVSR_SERVO) : PRESC_W'(DVSR_FAST);
    tick     = en_i && (q_q == dvsr);
    boundary = tick && (d_q == {RES{1'b1}});
    q_d      = q_q + PRESC_W'(1);
    d_d      = d_q;
    if (!en_i) begin
      q_d = '0;
      d_d = '0;
    end else if (tick) begin
      q_d = '0;
      d_d = d_q + RES'(1);
    end
  end

  // Handshake: a write transfers on a clock edge where wr_valid_i && wr_ready_o; ready is low only
  // while the addressed in-range channel already holds an uncommitted value.
  always_comb begin
    chan_ok    = 1'b0;
    wr_ready_o = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_chan_i == CW'(c)) begin
        chan_ok    = 1'b1;
        wr_ready_o = ~pend_q[c];
      end
    end
  end

  assign accept = wr_valid_i && wr_ready_o;

  // Commit uses the pend flags from before this edge, so a write landing on the boundary waits a period.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    mode_d    = mode_q;
    pwm_d     = '0;
    if (boundary) begin
      mode_d = mode_i;
      for (int c = 0; c < CHANNELS; c++) begin
        if (pend_q[c]) begin
          active_d[c] = thr(pending_q[c], mode_q);
          pend_d[c]   = 1'b0;
        end
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && (wr_chan_i == CW'(c))) begin
        pending_d[c] = wr_duty_i;
        pend_d[c]    = 1'b1;
      end
      pwm_d[c] = en_i && (d_q < active_q[c]);
    end
    err_d    = accept && !chan_ok;
    period_d = boundary;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q       <= '0;
      d_q       <= '0;
      active_q  <= '{default: '0};
      pending_q <= '{default: '0};
      pend_q    <= '0;
      mode_q    <= 1'b0;
      pwm_q     <= '0;
      period_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      d_q       <= d_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      pwm_q     <= pwm_d;
      period_q  <= period_d;
      err_q     <= err_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign period_o = period_q;
  assign wr_err_o = err_q;

endmodule
